// File: rtl/dual_stack_ctrl.sv
// Command-side initiator for the dual-stack storage block.
// Checks stack flags, issues push/pop strobes and returns one response per command.
module dual_stack_ctrl #(
    parameter int DATA_W = 8,
    parameter int ERR_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic              cmd_sel,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic [ERR_W-1:0]  err_count,
    output logic              stack_select,
    output logic              push,
    output logic              pop,
    output logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] data_out,
    input  logic              s1_empty,
    input  logic              s1_full,
    input  logic              s2_empty,
    input  logic              s2_full
);

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_PUSH = 2'b01;
    localparam logic [1:0] OP_POP  = 2'b10;
    localparam logic [1:0] OP_MOVE = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        MOVEPUSH,
        RESP
    } state_e;

    state_e            state_q;
    logic [1:0]        op_q;
    logic              sel_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic              rsp_err_q;
    logic [ERR_W-1:0]  err_q;
    logic              ss_q;
    logic [DATA_W-1:0] din_q;

    logic src_empty;
    logic src_full;
    logic dst_full;
    logic issue_err;
    logic push_issue;
    logic pop_issue;
    logic push_move;

    assign src_empty = sel_q ? s2_empty : s1_empty;
    assign src_full  = sel_q ? s2_full  : s1_full;
    assign dst_full  = sel_q ? s1_full  : s2_full;

    always_comb begin
        issue_err = 1'b0;
        unique case (op_q)
            OP_NOP:  issue_err = 1'b0;
            OP_PUSH: issue_err = src_full;
            OP_POP:  issue_err = src_empty;
            OP_MOVE: issue_err = src_empty | dst_full;
        endcase
    end

    // Strobes decode from the state so the ISSUE-cycle flags gate them directly.
    assign push_issue = (state_q == ISSUE) && (op_q == OP_PUSH) && !issue_err;
    assign pop_issue  = (state_q == ISSUE) && op_q[1] && !issue_err;
    assign push_move  = (state_q == MOVEPUSH);

    assign push = push_issue | push_move;
    assign pop  = pop_issue;

    always_comb begin
        stack_select = ss_q;
        data_in      = din_q;
        if (push_issue || pop_issue) begin
            stack_select = sel_q;
        end else if (push_move) begin
            stack_select = ~sel_q;
        end
        if (push_issue) begin
            data_in = wdata_q;
        end else if (push_move) begin
            data_in = rsp_data_q;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign err_count = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            op_q       <= OP_NOP;
            sel_q      <= 1'b0;
            wdata_q    <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            err_q      <= '0;
            ss_q       <= 1'b0;
            din_q      <= '0;
        end else begin
            if (push || pop) begin
                ss_q <= stack_select;
            end
            if (push) begin
                din_q <= data_in;
            end
            unique case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        op_q       <= cmd_op;
                        sel_q      <= cmd_sel;
                        wdata_q    <= cmd_data;
                        rsp_data_q <= '0;
                        rsp_err_q  <= 1'b0;
                        state_q    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (issue_err) begin
                        rsp_err_q <= 1'b1;
                        if (err_q != {ERR_W{1'b1}}) begin
                            err_q <= err_q + 1'b1;
                        end
                        state_q <= RESP;
                    end else if (op_q[1]) begin
                        state_q <= CAPTURE;
                    end else begin
                        state_q <= RESP;
                    end
                end
                CAPTURE: begin
                    rsp_data_q <= data_out;
                    state_q    <= (op_q == OP_MOVE) ? MOVEPUSH : RESP;
                end
                MOVEPUSH: begin
                    state_q <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dual_stack_ctrl.sv
// Self-checking bench for dual_stack_ctrl: behavioural dual stack,
// reference model feeding a response scoreboard, plus directed timing checks.
module tb_dual_stack_ctrl;

    localparam int DW    = 8;
    localparam int EW    = 8;
    localparam int DEPTH = 4;

    logic          clk;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic          cmd_sel;
    logic [DW-1:0] cmd_data;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;
    logic [EW-1:0] err_count;
    logic          stack_select;
    logic          push;
    logic          pop;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_out;
    logic          s1_empty;
    logic          s1_full;
    logic          s2_empty;
    logic          s2_full;

    dual_stack_ctrl #(.DATA_W(DW), .ERR_W(EW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_sel      (cmd_sel),
        .cmd_data     (cmd_data),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_err      (rsp_err),
        .err_count    (err_count),
        .stack_select (stack_select),
        .push         (push),
        .pop          (pop),
        .data_in      (data_in),
        .data_out     (data_out),
        .s1_empty     (s1_empty),
        .s1_full      (s1_full),
        .s2_empty     (s2_empty),
        .s2_full      (s2_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural storage
    logic [DW-1:0] mem [2][DEPTH];
    int cnt [2];
    initial begin
        cnt[0] = 0;
        cnt[1] = 0;
        data_out = '0;
    end
    assign s1_empty = (cnt[0] == 0);
    assign s1_full  = (cnt[0] == DEPTH);
    assign s2_empty = (cnt[1] == 0);
    assign s2_full  = (cnt[1] == DEPTH);

    always @(posedge clk) begin
        int s;
        s = stack_select ? 1 : 0;
        if (push && cnt[s] < DEPTH) begin
            mem[s][cnt[s]] <= data_in;
            cnt[s] <= cnt[s] + 1;
        end
        if (pop && cnt[s] > 0) begin
            data_out <= mem[s][cnt[s]-1];
            cnt[s] <= cnt[s] - 1;
        end
    end

    // Reference model and scoreboard
    typedef struct {
        logic          err;
        logic [DW-1:0] data;
        int            lat;
        int            t;
        logic [EW-1:0] ec;
    } exp_t;

    exp_t          sb [$];
    logic [DW-1:0] rq0 [$];
    logic [DW-1:0] rq1 [$];
    logic [EW-1:0] ec_m = '0;

    int            tcmd;
    int            push_cyc, pop_cyc, n_push, n_pop;
    logic          push_sel, pop_sel;
    logic [DW-1:0] push_dat;
    int            first_cyc;
    logic          rv_prev = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (rsp_valid && !rv_prev) first_cyc = cyc;
        rv_prev = rsp_valid;
        if (push) begin
            push_cyc = cyc;
            push_sel = stack_select;
            push_dat = data_in;
            n_push++;
            chk("push_legal", stack_select ? s2_full : s1_full, 0);
        end
        if (pop) begin
            pop_cyc = cyc;
            pop_sel = stack_select;
            n_pop++;
            chk("pop_legal", stack_select ? s2_empty : s1_empty, 0);
        end
        if (push || pop) chk("strobe_excl", push & pop, 0);
        if (rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("rsp_data", rsp_data, e.data);
                chk("rsp_err", rsp_err, e.err);
                chk("rsp_lat", first_cyc - e.t, e.lat);
                chk("err_count", err_count, e.ec);
            end
        end
    end

    task automatic send(input logic [1:0] op, input logic sel, input logic [DW-1:0] d);
        exp_t e;
        int   k;
        k = 0;
        @(posedge clk); #1;
        while (!cmd_ready && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        if (!cmd_ready) chk("cmd_ready_timeout", cmd_ready, 1);
        e.err  = 1'b0;
        e.data = '0;
        e.lat  = 2;
        e.t    = cyc;
        unique case (op)
            2'b00: ;
            2'b01: begin
                if ((sel ? rq1.size() : rq0.size()) == DEPTH) e.err = 1'b1;
                else if (sel) rq1.push_back(d);
                else rq0.push_back(d);
            end
            2'b10: begin
                if ((sel ? rq1.size() : rq0.size()) == 0) e.err = 1'b1;
                else begin
                    e.data = sel ? rq1.pop_back() : rq0.pop_back();
                    e.lat  = 3;
                end
            end
            2'b11: begin
                if ((sel ? rq1.size() : rq0.size()) == 0 ||
                    (sel ? rq0.size() : rq1.size()) == DEPTH) e.err = 1'b1;
                else begin
                    e.data = sel ? rq1.pop_back() : rq0.pop_back();
                    if (sel) rq0.push_back(e.data);
                    else rq1.push_back(e.data);
                    e.lat = 4;
                end
            end
        endcase
        if (e.err && ec_m != '1) ec_m = ec_m + 1'b1;
        e.ec = ec_m;
        sb.push_back(e);
        tcmd     = cyc;
        push_cyc = -1;
        pop_cyc  = -1;
        n_push   = 0;
        n_pop    = 0;
        cmd_op    = op;
        cmd_sel   = sel;
        cmd_data  = d;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 100) begin
            @(posedge clk);
            k++;
        end
        if (sb.size() != 0) begin
            chk("rsp_timeout", sb.size(), 0);
            sb.delete();
        end
        #1;
    endtask

    initial begin
        logic [DW-1:0] d0;
        int            k;
        rst_n     = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = 2'b01;
        cmd_sel   = 1'b0;
        cmd_data  = 8'hEE;
        rsp_ready = 1'b1;
        n_push = 0;
        n_pop  = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_err_count", err_count, 0);
        chk("rst_stack_select", stack_select, 0);
        chk("rst_push", push, 0);
        chk("rst_pop", pop, 0);
        chk("rst_data_in", data_in, 0);
        chk("rst_no_strobe", n_push + n_pop, 0);
        cmd_valid = 1'b0;
        rst_n = 1'b1;

        send(2'b01, 1'b0, 8'hA5);
        wait_done();
        chk("push_t1", push_cyc - tcmd, 1);
        chk("push_data", push_dat, 8'hA5);
        chk("push_sel", push_sel, 0);
        chk("push_no_pop", n_pop, 0);

        send(2'b10, 1'b0, 8'h00);
        wait_done();
        chk("pop_t1", pop_cyc - tcmd, 1);
        chk("pop_sel", pop_sel, 0);
        chk("pop_no_push", n_push, 0);

        send(2'b00, 1'b1, 8'h77);
        wait_done();
        chk("nop_strobes", n_push + n_pop, 0);

        send(2'b10, 1'b1, 8'h00);
        wait_done();
        chk("pop_err_no_strobe", n_push + n_pop, 0);
        chk("pop_err_count", err_count, 1);

        send(2'b01, 1'b0, 8'h3C);
        wait_done();
        send(2'b11, 1'b0, 8'h00);
        wait_done();
        chk("move_pop_t1", pop_cyc - tcmd, 1);
        chk("move_pop_sel", pop_sel, 0);
        chk("move_push_t3", push_cyc - tcmd, 3);
        chk("move_push_sel", push_sel, 1);
        chk("move_push_data", push_dat, 8'h3C);
        chk("hold_select", stack_select, 1);
        chk("hold_data_in", data_in, 8'h3C);

        send(2'b01, 1'b1, 8'h11);
        wait_done();
        send(2'b01, 1'b1, 8'h22);
        wait_done();
        send(2'b01, 1'b1, 8'h33);
        wait_done();
        send(2'b01, 1'b0, 8'h44);
        wait_done();
        chk("s2_full_setup", s2_full, 1);
        send(2'b11, 1'b0, 8'h00);
        wait_done();
        chk("move_full_no_strobe", n_push + n_pop, 0);
        chk("move_full_err_count", err_count, 2);

        rsp_ready = 1'b0;
        send(2'b10, 1'b1, 8'h00);
        k = 0;
        while (!rsp_valid && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        chk("stall_rsp_valid", rsp_valid, 1);
        d0 = rsp_data;
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", rsp_valid, 1);
            chk("stall_data", rsp_data, d0);
            chk("stall_cmd_ready", cmd_ready, 0);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("post_hs_cmd_ready", cmd_ready, 1);
        chk("post_hs_rsp_valid", rsp_valid, 0);
        wait_done();

        send(2'b11, 1'b0, 8'h00);
        @(posedge clk); #1;
        chk("rstmove_popped", pop_cyc - tcmd, 1);
        rst_n = 1'b0;
        sb.delete();
        void'(rq1.pop_back());
        ec_m = '0;
        #1;
        chk("mid_cmd_ready", cmd_ready, 1);
        chk("mid_rsp_valid", rsp_valid, 0);
        chk("mid_rsp_data", rsp_data, 0);
        chk("mid_rsp_err", rsp_err, 0);
        chk("mid_err_count", err_count, 0);
        chk("mid_stack_select", stack_select, 0);
        chk("mid_data_in", data_in, 0);
        repeat (2) @(posedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("mid_no_push", n_push, 0);
        chk("mid_err_count_after", err_count, 0);

        for (int i = 0; i < 260; i++) begin
            send(2'b10, 1'b0, 8'h00);
            wait_done();
            if (i == 254) chk("sat_reach", err_count, 255);
        end
        chk("sat_final", err_count, 255);

        send(2'b10, 1'b1, 8'h00);
        wait_done();
        chk("sb_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=%0d exp=0", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dual_stack_ctrl.md
# dual_stack_ctrl

Command-side initiator for the dual-stack storage block. Accepts push/pop/move commands on a valid/ready command port and checks the stack full/empty flags before issuing anything. It then drives the one-cycle `stack_select`/`push`/`pop` strobes, captures popped data and returns a response on a valid/ready response port. It sits between the top-level pin decoder and the dual stack, so the storage never sees an illegal push or pop.

## Interface
- `DATA_W`, default 8: word width; must match the stack.
- `ERR_W`, default 8: width of the saturating error counter.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  block can accept a command.
- `cmd_op`  in  2  00 NOP, 01 PUSH, 10 POP, 11 MOVE (pop selected stack, push onto the other).
- `cmd_sel`  in  1  target stack: 0 is stack 1, 1 is stack 2. For MOVE this is the source stack.
- `cmd_data`  in  DATA_W  push data; ignored for other ops.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer accepts response.
- `rsp_data`  out  DATA_W  popped or moved word; 0 for NOP, PUSH and errors.
- `rsp_err`  out  1  command rejected (flag violation).
- `err_count`  out  ERR_W  rejected-command count; saturates at all-ones.
- `stack_select`  out  1  stack select to storage.
- `push`  out  1  one-cycle push strobe.
- `pop`  out  1  one-cycle pop strobe.
- `data_in`  out  DATA_W  push data to storage.
- `data_out`  in  DATA_W  storage read data; valid the cycle after the `pop` strobe.
- `s1_empty`, `s1_full`, `s2_empty`, `s2_full`  in  1 each  storage flags.

## Operation
- FSM states:
  - IDLE: `cmd_ready`=1.
  - ISSUE: flag check; PUSH/POP strobe.
  - CAPTURE: register `data_out`.
  - MOVEPUSH: push the captured word to the other stack.
  - RESP: `rsp_valid`=1.
- IDLE → ISSUE when `cmd_valid` & `cmd_ready`. The command fields are registered at that edge.
- Error checks in ISSUE, against the flags sampled that cycle:
  - PUSH errors if the selected stack is full.
  - POP errors if the selected stack is empty.
  - MOVE errors if the source is empty or the destination is full.
- On error: no strobe, go to RESP with `rsp_err`=1, `rsp_data`=0, and increment `err_count` (saturating).
- NOP: ISSUE → RESP, no strobe, `rsp_err`=0.
- PUSH: `push`=1, `stack_select`=`cmd_sel`, `data_in`=`cmd_data` in ISSUE, then go to RESP.
- POP: `pop`=1, `stack_select`=`cmd_sel` in ISSUE. In CAPTURE, `rsp_data` ← `data_out`. Then go to RESP.
- MOVE: pop the source in ISSUE and capture in CAPTURE. In MOVEPUSH: `push`=1, `stack_select`=~`cmd_sel`, `data_in`=captured word. Then go to RESP with `rsp_data`=moved word.
- RESP holds `rsp_valid`, `rsp_data` and `rsp_err` stable until `rsp_ready`. On the handshake, go to IDLE.
- Only one command is in flight; `cmd_ready`=0 in every state except IDLE.
- `push` and `pop` are never both high; each is high for at most one cycle per command.
- `stack_select` and `data_in` hold their last driven value between commands.

## Timing
- Let T be the cycle in which the command handshake occurs.
- PUSH / NOP / error: strobe (if any) in T+1; `rsp_valid` from T+2.
- POP: `pop` in T+1; `data_out` sampled at the end of T+2; `rsp_valid` from T+3.
- MOVE: `pop` in T+1, capture in T+2, `push` in T+3, `rsp_valid` from T+4.
- Earliest next command acceptance: the cycle after the response handshake.
- Reset values: state IDLE, `cmd_ready`=1 (commands ignored while `rst_n` low), `rsp_valid`=0, `rsp_data`=0, `rsp_err`=0, `err_count`=0, `stack_select`=0, `push`=0, `pop`=0, `data_in`=0.
- Reset mid-operation: aborts immediately; the in-flight command and response are discarded and no further strobes are issued. A MOVE reset after its pop loses the word; this is accepted behaviour.
- Flags changing after ISSUE are ignored for that command.

## Test plan
- PUSH sel=0 data 0xA5, then POP sel=0 → `push` pulse in T+1 with `data_in`=0xA5; the POP response has `rsp_data`=0xA5, `rsp_err`=0, and `rsp_valid` at T+3.
- POP sel=1 with `s2_empty`=1 → no `pop` strobe; response `rsp_err`=1, `rsp_data`=0; `err_count` 0→1.
- MOVE sel=0 after pushing 0x3C to stack 1 → `pop` with `stack_select`=0 at T+1, `push` with `stack_select`=1 and `data_in`=0x3C at T+3, `rsp_data`=0x3C at T+4.
- MOVE sel=0 with `s2_full`=1 → no strobes, `rsp_err`=1.
- `rsp_ready` held low 5 cycles → `rsp_valid`/`rsp_data` stable and `cmd_ready`=0 throughout; `cmd_ready`=1 the cycle after the handshake.
- `rst_n` pulsed during MOVE CAPTURE → no `push` strobe afterwards; all outputs at reset values; `err_count`=0.
- 260 error commands → `err_count` saturates at 255.
